pmem_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read program memory between the fetch stage and a program loader/debug port.
//  The fetch stage owns the memory by default. A loader request stalls fetch, grants the loader a write/read burst,

---
 rtl/pmem_arbiter.sv | 87 ++++++++
 tb/tb_pmem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares program memory between fetch and the loader; define PMEM_ARB_FAIRNESS_EN to cap loader bursts at MAX_BURST
module pmem_arbiter #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [PC_WIDTH-1:0]   fe_addr_i,
  output logic                  fe_stall_o,
  output logic                  fe_flush_o,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic [PC_WIDTH-1:0]   ld_addr_i,
  input  logic [PMEM_WIDTH-1:0] ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [PMEM_WIDTH-1:0] ld_rdata_o,
  output logic [PC_WIDTH-1:0]   mem_addr_o,
  output logic                  mem_we_o,
  output logic [PMEM_WIDTH-1:0] mem_wdata_o,
  input  logic [PMEM_WIDTH-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {FETCH, LOAD, REFILL} state_e;
  state_e state_q, state_d;
  logic xfer;
  logic burst_end;
  logic ld_rvalid_q;
  logic [PMEM_WIDTH-1:0] ld_rdata_q;
  assign xfer = (state_q == LOAD) && ld_req_i;
`ifdef PMEM_ARB_FAIRNESS_EN
  localparam int CW = ($clog2(MAX_BURST + 1) < 3) ? 3 : $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  assign burst_end = xfer && (burst_cnt_q == CW'(MAX_BURST - 1));
  // counts transfers in the current grant; fetch ownership clears it
  always_comb begin
    burst_cnt_d = (state_q == FETCH) ? '0 : xfer ? burst_cnt_q + 1'b1 : burst_cnt_q;
  end
  // burst counter register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) burst_cnt_q <= '0;
    else         burst_cnt_q <= burst_cnt_d;
  end
`else
  assign burst_end = 1'b0;
`endif
  // next ownership and memory-port steering, decoded from the owner state
  always_comb begin
    state_d     = FETCH;
    ld_gnt_o    = 1'b0;
    fe_stall_o  = 1'b0;
    fe_flush_o  = 1'b0;
    mem_addr_o  = fe_addr_i;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (state_q == FETCH) begin
      state_d = ld_req_i ? LOAD : FETCH;
    end else if (state_q == LOAD) begin
      state_d     = (!ld_req_i || burst_end) ? REFILL : LOAD;
      ld_gnt_o    = 1'b1;
      fe_stall_o  = 1'b1;
      mem_addr_o  = ld_addr_i;
      mem_we_o    = ld_req_i & ld_we_i;
      mem_wdata_o = ld_wdata_i;
    end else if (state_q == REFILL) begin
      fe_stall_o = 1'b1;
      fe_flush_o = 1'b1;
    end
  end
  // owner state; async reset drops a loader grant instantly so no write slips through
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= FETCH;
    else         state_q <= state_d;
  end
  // read return: memory data arrives the cycle after the read transfer, then is held
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      ld_rvalid_q <= xfer & ~ld_we_i;
      ld_rdata_q  <= ld_rvalid_q ? mem_rdata_i : ld_rdata_q;
    end
  end
  assign ld_rvalid_o = ld_rvalid_q;
  assign ld_rdata_o  = ld_rvalid_q ? mem_rdata_i : ld_rdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: randomized and directed checks of pmem_arbiter against an ownership/memory reference model
module tb_pmem_arbiter;
  localparam int MB = 4;
`ifdef PMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic [11:0] fe_addr = '0, ld_addr = '0, mem_addr;
  logic [15:0] ld_wdata = '0, ld_rdata, mem_wdata, mem_rdata;
  logic ld_req = 1'b0, ld_we = 1'b0;
  logic fe_stall, fe_flush, ld_gnt, ld_rvalid, mem_we;
  logic [15:0] pmem [0:4095];
  logic [15:0] ref_mem [0:4095];
  int checks = 0;
  int failures = 0;
  int phase, prev_phase, bcnt;
  logic exp_rvalid;
  logic [15:0] exp_rdata;
  logic [11:0] prev_fe;
  logic r = 1'b0, w = 1'b0;
  logic [11:0] a = '0, f = '0;
  logic [15:0] d = '0;
  always #5 clk = ~clk;
  pmem_arbiter #(.PC_WIDTH(12), .PMEM_WIDTH(16), .MAX_BURST(MB)) dut (
    .clock_i(clk), .reset_i(rst), .fe_addr_i(fe_addr), .fe_stall_o(fe_stall), .fe_flush_o(fe_flush),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  function automatic logic [15:0] init_val(input int i);
    return i == 0 ? 16'h1111 : i == 2 ? 16'h2222 : i == 4 ? 16'h3333 : 16'(i * 7 + 3);
  endfunction
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) pmem[i] <= init_val(i);
    end else if (mem_we) pmem[mem_addr] <= mem_wdata;
    mem_rdata <= pmem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    phase = 0; prev_phase = 0; bcnt = 0; exp_rvalid = 1'b0; exp_rdata = '0; prev_fe = '0;
  endtask
  task automatic cyc(input logic rq, input logic wq, input logic [11:0] aq, input logic [15:0] dq, input logic [11:0] fq);
    logic tr;
    @(posedge clk);
    #1;
    ld_req = rq; ld_we = wq; ld_addr = aq; ld_wdata = dq; fe_addr = fq;
    @(negedge clk);
    tr = (phase == 1) && rq;
    chk("fe_stall", fe_stall, phase != 0);
    chk("fe_flush", fe_flush, phase == 2);
    chk("ld_gnt", ld_gnt, phase == 1);
    chk("mem_we", mem_we, tr && wq);
    chk("mem_addr", mem_addr, phase == 1 ? aq : fq);
    if (tr && wq) chk("mem_wdata", mem_wdata, dq);
    chk("ld_rvalid", ld_rvalid, exp_rvalid);
    chk("ld_rdata", ld_rdata, exp_rdata);
    if (prev_phase == 2) chk("refill_word", mem_rdata, ref_mem[prev_fe]);
    prev_phase = phase;
    prev_fe = fq;
    exp_rvalid = tr && !wq;
    if (exp_rvalid) exp_rdata = ref_mem[aq];
    if (tr && wq) ref_mem[aq] = dq;
    if (phase == 0) begin
      bcnt = 0;
      phase = rq ? 1 : 0;
    end else if (phase == 1) begin
      bcnt += int'(rq);
      phase = (!rq || (FAIR && bcnt == MB)) ? 2 : 1;
    end else phase = 0;
  endtask
  initial begin
    int k;
    logic was_load;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", ld_gnt, 0);
    chk("rst_stall", fe_stall, 0);
    chk("rst_flush", fe_flush, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rvalid", ld_rvalid, 0);
    chk("rst_rdata", ld_rdata, 0);
    preload = 1'b0;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 12'h100, 16'hDEAD, 12'h010);
    @(posedge clk);
    #1;
    chk("load_we", mem_we, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_gnt", ld_gnt, 0);
    chk("abort_stall", fe_stall, 0);
    @(posedge clk);
    @(negedge clk);
    ld_req = 1'b0;
    rst = 1'b0;
    mreset();
    chk("abort_nowrite", pmem[12'h100], ref_mem[12'h100]);
    repeat (4) cyc(1'b0, 1'b0, 12'h0, 16'h0, 12'h010);
    repeat (2) cyc(1'b1, 1'b1, 12'h020, 16'hBEEF, 12'h010);
    repeat (3) cyc(1'b0, 1'b0, 12'h020, 16'h0, 12'h010);
    chk("write_beef", pmem[12'h020], 16'hBEEF);
    cyc(1'b1, 1'b0, 12'h000, 16'h0, 12'h010);
    cyc(1'b1, 1'b0, 12'h000, 16'h0, 12'h010);
    cyc(1'b1, 1'b0, 12'h002, 16'h0, 12'h010);
    chk("rd0", ld_rdata, 16'h1111);
    cyc(1'b1, 1'b0, 12'h004, 16'h0, 12'h010);
    chk("rd1", ld_rdata, 16'h2222);
    cyc(1'b0, 1'b0, 12'h004, 16'h0, 12'h010);
    chk("rd2", ld_rdata, 16'h3333);
    repeat (2) cyc(1'b0, 1'b0, 12'h0, 16'h0, 12'h010);
    repeat (2) cyc(1'b1, 1'b1, 12'h030, 16'hA5A5, 12'h030);
    repeat (3) cyc(1'b0, 1'b0, 12'h030, 16'h0, 12'h030);
    chk("refill_a5a5", mem_rdata, 16'hA5A5);
    k = 0;
    while (k < 10) begin
      was_load = (phase == 1);
      cyc(1'b1, 1'b1, 12'(12'h200 + 2 * k), 16'(16'hC000 + k), 12'h040);
      if (was_load) k++;
    end
    repeat (3) cyc(1'b0, 1'b0, 12'h0, 16'h0, 12'h040);
    for (int i = 0; i < 10; i++) chk("burst_write", pmem[12'h200 + 2 * i], 16'(16'hC000 + i));
    for (int i = 0; i < 600; i++) begin
      if (!(r && phase != 1)) begin
        r = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        w = 1'($urandom_range(0, 1));
        a = 12'($urandom_range(0, 31) * 2);
        d = 16'($urandom);
      end
      if (phase == 0) f = 12'($urandom_range(0, 31) * 2);
      cyc(r, w, a, d, f);
    end
    repeat (4) cyc(1'b0, 1'b0, 12'h0, 16'h0, f);
    for (int i = 0; i < 64; i += 2) chk("final_mem", pmem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
